// File: rtl/uart_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// uart_ctrl_pkg
// Shared definitions for the UART <-> ALU sequencer, the ALU and the benches.
//   - 3-bit state encodings for the sequencer FSM and the matching enum type.
//   - ALU opcode constants (6-bit function codes).
//   - is_busy_state(): the states in which the sequencer refuses new bytes.
// -----------------------------------------------------------------------------
package uart_ctrl_pkg;

  // Sequencer state encodings
  localparam logic [2:0] ENC_WAIT_A  = 3'd0;
  localparam logic [2:0] ENC_WAIT_B  = 3'd1;
  localparam logic [2:0] ENC_WAIT_OP = 3'd2;
  localparam logic [2:0] ENC_EXEC    = 3'd3;
  localparam logic [2:0] ENC_SEND    = 3'd4;
  localparam logic [2:0] ENC_WAIT_TX = 3'd5;

  typedef enum logic [2:0] {
    ST_WAIT_A  = ENC_WAIT_A,
    ST_WAIT_B  = ENC_WAIT_B,
    ST_WAIT_OP = ENC_WAIT_OP,
    ST_EXEC    = ENC_EXEC,
    ST_SEND    = ENC_SEND,
    ST_WAIT_TX = ENC_WAIT_TX
  } ctrl_state_t;

  // ALU opcodes
  localparam logic [5:0] OP_ADD = 6'h20;
  localparam logic [5:0] OP_SUB = 6'h22;
  localparam logic [5:0] OP_AND = 6'h24;
  localparam logic [5:0] OP_OR  = 6'h25;
  localparam logic [5:0] OP_XOR = 6'h26;
  localparam logic [5:0] OP_SRA = 6'h03;
  localparam logic [5:0] OP_SRL = 6'h02;
  localparam logic [5:0] OP_NOR = 6'h27;

  // States in which a transaction is in flight and received bytes are dropped.
  function automatic logic is_busy_state(input ctrl_state_t s);
    return (s == ST_EXEC) || (s == ST_SEND) || (s == ST_WAIT_TX);
  endfunction

endpackage

// File: rtl/uart_ctrl_timer.sv
// -----------------------------------------------------------------------------
// uart_ctrl_timer
// Inter-byte timeout counter. Counts enabled cycles from 0 and flags the
// terminal count (CYCLES-1) combinationally while enabled.
// Ports:
//   i_clk     in  1  clock, rising edge
//   i_reset   in  1  asynchronous active-low reset, clears the count
//   i_clear   in  1  synchronous clear (has priority over i_enable)
//   i_enable  in  1  count this cycle
//   o_tc      out 1  enabled and count == CYCLES-1
// Parameters:
//   CYCLES    number of cycles until terminal count (>= 1)
// -----------------------------------------------------------------------------
module uart_ctrl_timer #(
  parameter int CYCLES = 1000000
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_tc
);

  localparam int W = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [W-1:0] LAST = W'(CYCLES - 1);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (i_clear) begin
      count_d = '0;
    end else if (i_enable) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign o_tc = i_enable && (count_q == LAST);

endmodule

// File: rtl/uart_alu_ctrl.sv
// -----------------------------------------------------------------------------
// uart_alu_ctrl
// Sequencer between a UART receiver/transmitter pair and a combinational ALU.
// Collects operand A, operand B and opcode bytes, lets the ALU settle for one
// cycle, captures the result, requests a transmit and waits for it to finish.
//
// Ports:
//   i_clk         in   1          clock, rising edge
//   i_reset       in   1          asynchronous active-low reset
//   i_rx_done     in   1          receiver pulse: i_rx_data valid
//   i_rx_data     in   DATA_BITS  received byte
//   i_tx_done     in   1          transmitter pulse: byte sent
//   i_alu_result  in   DATA_BITS  ALU result (combinational from o_alu_*)
//   o_alu_a       out  DATA_BITS  operand A register
//   o_alu_b       out  DATA_BITS  operand B register
//   o_alu_op      out  OP_BITS    opcode register
//   o_tx_start    out  1          one-cycle transmit request (high in SEND)
//   o_tx_data     out  DATA_BITS  result register
//   o_busy        out  1          high in EXEC, SEND, WAIT_TX
//   o_timeout     out  1          one-cycle inter-byte timeout pulse
//
// Build option: define UART_CTRL_TIMEOUT_EN to enable the inter-byte timeout in
// WAIT_B / WAIT_OP. Without it o_timeout is tied low and waits are unbounded.
// -----------------------------------------------------------------------------
module uart_alu_ctrl
  import uart_ctrl_pkg::*;
#(
  parameter int DATA_BITS      = 8,
  parameter int OP_BITS        = 6,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_rx_done,
  input  logic [DATA_BITS-1:0] i_rx_data,
  input  logic                 i_tx_done,
  input  logic [DATA_BITS-1:0] i_alu_result,
  output logic [DATA_BITS-1:0] o_alu_a,
  output logic [DATA_BITS-1:0] o_alu_b,
  output logic [OP_BITS-1:0]   o_alu_op,
  output logic                 o_tx_start,
  output logic [DATA_BITS-1:0] o_tx_data,
  output logic                 o_busy,
  output logic                 o_timeout
);

  ctrl_state_t          state_q,    state_d;
  logic [DATA_BITS-1:0] alu_a_q,    alu_a_d;
  logic [DATA_BITS-1:0] alu_b_q,    alu_b_d;
  logic [OP_BITS-1:0]   alu_op_q,   alu_op_d;
  logic [DATA_BITS-1:0] tx_data_q,  tx_data_d;
  logic                 tx_start_q, tx_start_d;
  logic                 busy_q,     busy_d;
  logic                 timeout_q,  timeout_d;

  // Terminal count reached with no byte arriving in the same cycle.
  logic tmo_hit;

`ifdef UART_CTRL_TIMEOUT_EN
  logic timer_en;
  logic timer_clr;
  logic timer_tc;

  assign timer_en  = (state_q == ST_WAIT_B) || (state_q == ST_WAIT_OP);
  // Restart on every accepted byte, on a timeout and whenever not waiting.
  assign timer_clr = !timer_en || i_rx_done || tmo_hit;
  // A byte on the terminal cycle wins over the timeout.
  assign tmo_hit   = timer_tc && !i_rx_done;

  uart_ctrl_timer #(
    .CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_clear  (timer_clr),
    .i_enable (timer_en),
    .o_tc     (timer_tc)
  );
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_op_d   = alu_op_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    timeout_d  = 1'b0;

    case (state_q)
      ST_WAIT_A: begin
        if (i_rx_done) begin
          alu_a_d = i_rx_data;
          state_d = ST_WAIT_B;
        end
      end
      ST_WAIT_B: begin
        if (i_rx_done) begin
          alu_b_d = i_rx_data;
          state_d = ST_WAIT_OP;
        end else if (tmo_hit) begin
          alu_a_d   = '0;
          alu_b_d   = '0;
          alu_op_d  = '0;
          timeout_d = 1'b1;
          state_d   = ST_WAIT_A;
        end
      end
      ST_WAIT_OP: begin
        if (i_rx_done) begin
          alu_op_d = i_rx_data[OP_BITS-1:0];
          state_d  = ST_EXEC;
        end else if (tmo_hit) begin
          alu_a_d   = '0;
          alu_b_d   = '0;
          alu_op_d  = '0;
          timeout_d = 1'b1;
          state_d   = ST_WAIT_A;
        end
      end
      ST_EXEC: begin
        // Operands have been stable for a full cycle; the result is settled.
        tx_data_d  = i_alu_result;
        tx_start_d = 1'b1;  // registered so it is high exactly while in SEND
        state_d    = ST_SEND;
      end
      ST_SEND: begin
        state_d = ST_WAIT_TX;
      end
      ST_WAIT_TX: begin
        if (i_tx_done) begin
          state_d = ST_WAIT_A;
        end
      end
      default: begin
        state_d = ST_WAIT_A;
      end
    endcase

    // Registered Moore output: derived from the state being entered.
    busy_d = is_busy_state(state_d);
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q    <= ST_WAIT_A;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_op_q   <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_op_q   <= alu_op_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      busy_q     <= busy_d;
      timeout_q  <= timeout_d;
    end
  end

  assign o_alu_a    = alu_a_q;
  assign o_alu_b    = alu_b_q;
  assign o_alu_op   = alu_op_q;
  assign o_tx_data  = tx_data_q;
  assign o_tx_start = tx_start_q;
  assign o_busy     = busy_q;
  assign o_timeout  = timeout_q;

endmodule

// File: tb/tb_uart_alu_ctrl.sv
// -----------------------------------------------------------------------------
// tb_uart_alu_ctrl
// Self-checking bench for uart_alu_ctrl. A behavioural ALU drives i_alu_result
// from the DUT operand registers; a transaction-level model predicts captured
// operands and the transmitted result. Timeout cases run when the design is
// built with UART_CTRL_TIMEOUT_EN.
// -----------------------------------------------------------------------------
module tb_uart_alu_ctrl;
  import uart_ctrl_pkg::*;

  localparam int DB  = 8;
  localparam int OB  = 6;
  localparam int TMO = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rx_done = 1'b0;
  logic [DB-1:0] rx_data = '0;
  logic          tx_done = 1'b0;
  logic [DB-1:0] alu_result;
  logic [DB-1:0] o_alu_a;
  logic [DB-1:0] o_alu_b;
  logic [OB-1:0] o_alu_op;
  logic          o_tx_start;
  logic [DB-1:0] o_tx_data;
  logic          o_busy;
  logic          o_timeout;

  int n_checks = 0;
  int n_pass   = 0;

  logic [DB-1:0] model_a  = '0;
  logic [DB-1:0] model_b  = '0;
  logic [OB-1:0] model_op = '0;
  logic          tmo_seen = 1'b0;

  always #5 clk = ~clk;

  uart_alu_ctrl #(
    .DATA_BITS      (DB),
    .OP_BITS        (OB),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .i_clk        (clk),
    .i_reset      (rst_n),
    .i_rx_done    (rx_done),
    .i_rx_data    (rx_data),
    .i_tx_done    (tx_done),
    .i_alu_result (alu_result),
    .o_alu_a      (o_alu_a),
    .o_alu_b      (o_alu_b),
    .o_alu_op     (o_alu_op),
    .o_tx_start   (o_tx_start),
    .o_tx_data    (o_tx_data),
    .o_busy       (o_busy),
    .o_timeout    (o_timeout)
  );

  function automatic logic [DB-1:0] alu_model(input logic [DB-1:0] a,
                                              input logic [DB-1:0] b,
                                              input logic [OB-1:0] op);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_SRA:  return DB'($signed(a) >>> b);
      OP_SRL:  return a >> b;
      OP_NOR:  return ~(a | b);
      default: return a ^ b ^ 8'hA5;
    endcase
  endfunction

  assign alu_result = alu_model(o_alu_a, o_alu_b, o_alu_op);

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [DB-1:0] b);
    rx_done = 1'b1;
    rx_data = b;
    tx_done = 1'b0;
    step();
    rx_done = 1'b0;
    rx_data = DB'($urandom);
  endtask

  // Idle cycles while waiting for a byte, with stray tx_done pulses.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      tx_done = ($urandom_range(0, 3) == 0);
      step();
      if (o_timeout) tmo_seen = 1'b1;
    end
    tx_done = 1'b0;
  endtask

  // One complete transaction starting in WAIT_A; returns in the first WAIT_A
  // cycle after i_tx_done, so consecutive calls are back-to-back.
  task automatic run_txn(input logic [DB-1:0] a, input logic [DB-1:0] b,
                         input logic [DB-1:0] opb, input int gap, input int txwait);
    logic [DB-1:0] exp;
    exp      = alu_model(a, b, opb[OB-1:0]);
    tmo_seen = 1'b0;

    send_byte(a);
    model_a = a;
    check_eq("a_capture", 32'(o_alu_a), 32'(model_a));
    check_eq("busy_in_wait", 32'(o_busy), 32'(0));
    idle(gap);
    send_byte(b);
    model_b = b;
    check_eq("b_capture", 32'(o_alu_b), 32'(model_b));
    check_eq("a_hold", 32'(o_alu_a), 32'(model_a));
    idle(gap);
    send_byte(opb);
    model_op = opb[OB-1:0];
    // EXEC cycle
    check_eq("op_capture", 32'(o_alu_op), 32'(model_op));
    check_eq("tx_start_exec", 32'(o_tx_start), 32'(0));
    check_eq("busy_exec", 32'(o_busy), 32'(1));
    rx_done = 1'b1;
    rx_data = 8'hFF;
    tx_done = 1'b1;
    step();
    // SEND cycle: two cycles after the opcode pulse
    check_eq("tx_start_send", 32'(o_tx_start), 32'(1));
    check_eq("tx_data", 32'(o_tx_data), 32'(exp));
    rx_data = ~a;
    step();
    rx_done = 1'b0;
    tx_done = 1'b0;
    check_eq("tx_start_width", 32'(o_tx_start), 32'(0));
    for (int i = 0; i < txwait; i++) begin
      rx_done = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      rx_data = (i == 0) ? 8'hFF : DB'($urandom);
      step();
    end
    rx_done = 1'b0;
    check_eq("busy_wait_tx", 32'(o_busy), 32'(1));
    check_eq("a_no_capture_busy", 32'(o_alu_a), 32'(model_a));
    check_eq("b_no_capture_busy", 32'(o_alu_b), 32'(model_b));
    check_eq("op_no_capture_busy", 32'(o_alu_op), 32'(model_op));
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    check_eq("busy_after_tx_done", 32'(o_busy), 32'(0));
    check_eq("tx_data_hold", 32'(o_tx_data), 32'(exp));
    check_eq("no_timeout", 32'(tmo_seen | o_timeout), 32'(0));
  endtask

  logic [OB-1:0] op_tbl [8];
  int            first_tmo;
  int            n_tmo;

  initial begin
    op_tbl = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SRA, OP_SRL, OP_NOR};

    // Reset state
    repeat (3) step();
    check_eq("rst_alu_a", 32'(o_alu_a), 32'(0));
    check_eq("rst_tx_start", 32'(o_tx_start), 32'(0));
    check_eq("rst_busy", 32'(o_busy), 32'(0));
    check_eq("rst_timeout", 32'(o_timeout), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Basic ADD
    run_txn(8'h05, 8'h03, {2'b00, OP_ADD}, 0, 1);
    check_eq("t1_add_result", 32'(o_tx_data), 32'h08);

    // SUB after bytes discarded while busy, back-to-back start
    run_txn(8'h0A, 8'h04, {2'b00, OP_SUB}, 1, 3);
    check_eq("t2_sub_result", 32'(o_tx_data), 32'h06);

    // Upper opcode bits dropped
    run_txn(8'h0F, 8'h33, 8'hE5, 2, 2);
    check_eq("t4_op_upper_dropped", 32'(o_alu_op), 32'h25);

    // Async reset while in SEND
    send_byte(8'h12);
    send_byte(8'h34);
    send_byte({2'b00, OP_XOR});
    step();
    check_eq("t3_pre_send", 32'(o_tx_start), 32'(1));
    rst_n = 1'b0;
    #1;
    check_eq("t3_rst_tx_start", 32'(o_tx_start), 32'(0));
    check_eq("t3_rst_busy", 32'(o_busy), 32'(0));
    check_eq("t3_rst_a", 32'(o_alu_a), 32'(0));
    check_eq("t3_rst_b", 32'(o_alu_b), 32'(0));
    check_eq("t3_rst_op", 32'(o_alu_op), 32'(0));
    check_eq("t3_rst_tx_data", 32'(o_tx_data), 32'(0));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    model_a = '0; model_b = '0; model_op = '0;
    check_eq("t3_post_rst_a", 32'(o_alu_a), 32'(0));
    run_txn(8'h21, 8'h12, {2'b00, OP_OR}, 0, 1);

`ifdef UART_CTRL_TIMEOUT_EN
    // Timeout after operand A
    send_byte(8'h11);
    first_tmo = -1;
    n_tmo     = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (o_timeout) begin
        n_tmo++;
        if (first_tmo < 0) first_tmo = i;
      end
      if (i == TMO) check_eq("t5_a_cleared", 32'(o_alu_a), 32'(0));
    end
    check_eq("t5_timeout_pulses", 32'(n_tmo), 32'(1));
    check_eq("t5_timeout_cycle", 32'(first_tmo), 32'(TMO));
    check_eq("t5_op_cleared", 32'(o_alu_op), 32'(0));
    // Byte on the terminal cycle wins
    send_byte(8'h21);
    repeat (TMO - 1) step();
    send_byte(8'h07);
    check_eq("t5_tc_no_timeout", 32'(o_timeout), 32'(0));
    check_eq("t5_tc_b_capture", 32'(o_alu_b), 32'h07);
    tmo_seen = 1'b0;
    idle(4);
    check_eq("t5_tc_quiet", 32'(tmo_seen), 32'(0));
    send_byte({2'b00, OP_ADD});
    step();
    check_eq("t5_tc_tx_start", 32'(o_tx_start), 32'(1));
    check_eq("t5_tc_tx_data", 32'(o_tx_data), 32'h28);
    step();
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    check_eq("t5_tc_idle", 32'(o_busy), 32'(0));
`else
    // Without the timer, a long gap between bytes is harmless
    run_txn(8'h40, 8'h02, {2'b00, OP_SRL}, 40, 2);
`endif

    // Randomized back-to-back transactions
    for (int t = 0; t < 24; t++) begin
      logic [DB-1:0] opb;
      if ($urandom_range(0, 3) == 0) opb = DB'($urandom);
      else opb = {2'($urandom), op_tbl[$urandom_range(0, 7)]};
      run_txn(DB'($urandom), DB'($urandom), opb, $urandom_range(0, 3), $urandom_range(1, 4));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
